// File: rtl/queue_pkg.sv
// +----------------------------------------------------------------------+
// | queue_pkg -- shared sizing helpers for queue_fifo. Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

package queue_pkg;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  localparam int DEF_DEPTH = 16;
  localparam int PW        = clog2(DEF_DEPTH);
  localparam int CW        = clog2(DEF_DEPTH + 1);

endpackage

`default_nettype wire

// File: rtl/queue_ptr.sv
// +----------------------------------------------------------------------+
// | queue_ptr -- wrap-around pointer register for queue_fifo. Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module queue_ptr
  import queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      inc,
  output logic [clog2(DEPTH)-1:0]   ptr
);

  localparam int P = clog2(DEPTH);
  localparam logic [P-1:0] C_LAST = P'(DEPTH - 1);

  logic [P-1:0] ptr_q;
  logic [P-1:0] ptr_d;

  // Explicit compare so non-power-of-two depths wrap correctly.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == C_LAST) ? '0 : ptr_q + P'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (clear) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/queue_fifo.sv
// +----------------------------------------------------------------------+
// | queue_fifo -- show-ahead synchronous FIFO with valid/ready. Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module queue_fifo
  import queue_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 16,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter int               AF_LEVEL = DEPTH - 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [clog2(DEPTH+1)-1:0]    count,
  output logic                         almost_full,
  output logic                         overflow
);

  localparam int P = clog2(DEPTH);
  localparam int C = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [P-1:0]     wp_q;
  logic [P-1:0]     rp_q;
  logic [C-1:0]     count_q;
  logic [C-1:0]     count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             push;
  logic             pop;

  assign in_ready    = (count_q != C'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign out_data    = mem_q[rp_q];
  assign count       = count_q;
  assign almost_full = (count_q >= C'(AF_LEVEL));
  assign overflow    = overflow_q;

  queue_ptr #(.DEPTH(DEPTH)) u_wp (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .inc   (push),
    .ptr   (wp_q)
  );

  queue_ptr #(.DEPTH(DEPTH)) u_rp (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .inc   (pop),
    .ptr   (rp_q)
  );

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);
    if (push && !pop) begin
      count_d = count_q + C'(1);
    end else if (pop && !push) begin
      count_d = count_q - C'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Clear leaves storage untouched; only reset reloads INIT.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT;
      end
    end else if (!clear && push) begin
      mem_q[wp_q] <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: doc/queue_fifo.md
Name: queue_fifo

Overview:
- Parametrised successor to the fixed-delay shift queue: a synchronous FIFO with valid/ready handshakes on both sides.
- Adds occupancy count, almost-full flag, synchronous flush and a sticky overflow flag.
- Sits between a producer and a consumer that may stall; replaces the shift queue wherever the delay must be elastic rather than fixed.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries (>=2; any value, not restricted to powers of two).
- INIT, 8'b0, value loaded into every storage entry on reset.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- clear  input  1  synchronous flush, active-high.
- in_data  input  WIDTH  write data.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  FIFO can accept a word.
- out_data  output  WIDTH  head-of-queue word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts out_data.
- count  output  CW  occupancy 0..DEPTH, where CW = clog2(DEPTH+1).
- almost_full  output  1  count >= AF_LEVEL.
- overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Storage: DEPTH x WIDTH register array; write pointer wp and read pointer rp, each 0..DEPTH-1; count register.
- Push: push = in_valid & in_ready. Writes mem[wp] and advances wp.
- Pop: pop = out_valid & out_ready. Advances rp.
- Wrap-around: a pointer at DEPTH-1 advances to 0. This must be an explicit compare, not power-of-two overflow.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational in/out path. When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0).
- out_data = mem[rp], combinational from registers, i.e. show-ahead. A word written at edge N is visible with out_valid=1 after edge N, so latency is 1 cycle when empty.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- almost_full = (count >= AF_LEVEL), decoded from the registered count.
- overflow: set when in_valid & !in_ready; held until reset or clear. It is set even in the same cycle a pop occurs while full.
- Pop while empty: out_ready with out_valid=0 is legal and has no effect.
- Reset (reset==0 at an edge):
  - wp=rp=0, count=0, overflow=0, every mem entry=INIT.
  - Resulting outputs: out_data=INIT, out_valid=0, in_ready=1, almost_full=(AF_LEVEL==0 ? 1 : 0), which is 0 for legal parameters.
  - Reset has priority over clear, push and pop. Reset mid-transfer discards all contents.
- clear (reset==1, clear==1):
  - wp=rp=0, count=0, overflow=0. mem is not modified, so out_data shows the old mem[0] with out_valid=0.
  - Any push/pop in the same cycle is ignored.
  - clear has priority over push/pop.
- There is no state machine beyond the pointers and count. All outputs except out_data and the flag decodes are registers.

Decomposition:
- Package queue_pkg:
  - clog2 constant function.
  - Derived localparams PW = clog2(DEPTH) (pointer width) and CW = clog2(DEPTH+1).
- Sub-module queue_ptr (parameter DEPTH): wrap-around pointer register.
  - Ports: clock, reset (active-low synchronous), clear, inc, ptr.
  - Instantiated twice, once for wp and once for rp.

Test Plan:
- Reset: hold reset=0 for 2 cycles with WIDTH=8, DEPTH=16, INIT=8'hA5 -> out_data=8'hA5, out_valid=0, in_ready=1, count=0, overflow=0.
- Fill/drain: push 8'h01..8'h10 with out_ready=0 -> count=16, in_ready=0, almost_full=1 from count=14. Then out_ready=1 -> reads 01..10 in order and count reaches 0.
- Overflow: at full, in_valid=1, in_ready=0 for 1 cycle with simultaneous pop -> overflow=1, count=15, word not stored. overflow stays 1 until clear=1.
- Simultaneous push/pop at count=5 for 20 cycles -> count stays 5. Data order is preserved across wp/rp wrap past 15->0.
- DEPTH=5 (non-power-of-two): 12 pushes interleaved with pops -> pointers wrap 4->0 and no word is lost or duplicated.
- Mid-stream: clear with count=7 -> next cycle count=0, out_valid=0, in_ready=1. Then reset=0 mid-push -> out_data=INIT and count=0.
